pipe_width_packer: RTL and testbench

PIPE_WIDTH_PACKER -- requirements
Module: pipe_width_packer

---
 rtl/pipe_width_packer.sv | 188 ++++++++++++++++++
 tb/tb_pipe_width_packer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_width_packer.sv
// pipe_width_packer: packs RATIO narrow input beats of DATAWIDTH bits into one
// wide output word (beat 0 in the least significant lane). The input side is a
// valid/ready stream that only stalls on the final lane when the previous word
// is still waiting downstream. The output word and its valid are registered.
//
// Optional feature: define PIPE_WIDTH_PACKER_LAST_EN to add in_last, out_last
// and out_lanes. With it, a beat carrying in_last closes the word early: the
// unfilled upper lanes read as zero and out_lanes reports how many lanes hold
// data. Without the macro only full words are produced.
module pipe_width_packer #(
   parameter int DATAWIDTH = 8,
   parameter int RATIO     = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATAWIDTH-1:0]           in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [DATAWIDTH*RATIO-1:0]     out_data,
   output logic                           out_valid,
`ifdef PIPE_WIDTH_PACKER_LAST_EN
   input  logic                           in_last,
   output logic                           out_last,
   output logic [$clog2(RATIO+1)-1:0]     out_lanes,
`endif
   input  logic                           out_ready
);

   // Lane counter width; RATIO is at least 2 so this is at least 1 bit.
   localparam int CW = $clog2(RATIO);
   // Width of the lane-count output (must be able to hold RATIO itself).
   localparam int LW = $clog2(RATIO + 1);
   localparam int WW = DATAWIDTH * RATIO;
   localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

   // Lane counter: which lane the next accepted beat is written to.
   logic [CW-1:0]        cnt_q;
   logic [CW-1:0]        cnt_d;

   // Accumulator for the lanes below the top one; the top lane never needs
   // storage because it is taken straight from in_data when the word closes.
   logic [DATAWIDTH-1:0] acc_q [RATIO-1];
   logic [DATAWIDTH-1:0] acc_d [RATIO-1];

   // Registered output word and its valid flag.
   logic [WW-1:0]        out_data_q;
   logic                 out_valid_q;

   // Word that would be emitted if the current beat closes it.
   logic [WW-1:0]        word_d;

   // Handshake helpers.
   logic                 final_beat;
   logic                 accept;

`ifdef PIPE_WIDTH_PACKER_LAST_EN
   logic                 out_last_q;
   logic [LW-1:0]        out_lanes_q;
   logic [LW-1:0]        lanes_d;
`endif

   // ------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------

   // Decide whether the beat currently offered closes a word.
`ifdef PIPE_WIDTH_PACKER_LAST_EN
   assign final_beat = (cnt_q == LAST_LANE) || in_last;
`else
   assign final_beat = (cnt_q == LAST_LANE);
`endif

   // Only a closing beat can stall: it needs the output register to be free
   // (empty, or draining on this same edge). Lanes before it always go in.
   assign in_ready = !final_beat || !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // ------------------------------------------------------------------------
   // Word assembly
   // ------------------------------------------------------------------------

   // Each output lane takes the stored beat if that lane is already filled,
   // the live input if it is the lane being written now, and zero above it.
   // For a full word the counter sits on the top lane, so every lower lane
   // comes from the accumulator and the top lane from in_data.
   generate
      for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
         if (gi < RATIO - 1) begin : g_stored
            assign word_d[gi*DATAWIDTH +: DATAWIDTH] =
               (cnt_q > CW'(gi))  ? acc_q[gi] :
               (cnt_q == CW'(gi)) ? in_data   :
                                    {DATAWIDTH{1'b0}};
         end else begin : g_top
            assign word_d[gi*DATAWIDTH +: DATAWIDTH] =
               (cnt_q == CW'(gi)) ? in_data : {DATAWIDTH{1'b0}};
         end
      end
   endgenerate

`ifdef PIPE_WIDTH_PACKER_LAST_EN
   // Number of populated lanes in the word being closed: a full word reports
   // RATIO, an early-terminated one reports the lanes written so far plus the
   // current beat.
   assign lanes_d = in_last ? (LW'(cnt_q) + LW'(1)) : LW'(RATIO);
`endif

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------

   // Advance the lane counter on every accepted beat, back to lane 0 when
   // the beat closes the word.
   always_comb begin
      cnt_d = cnt_q;
      if (accept) begin
         if (final_beat) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Capture an accepted beat into its accumulator lane; nothing else moves
   // the accumulator, so in_data is ignored when no beat is taken.
   always_comb begin
      for (int i = 0; i < RATIO - 1; i++) begin
         acc_d[i] = acc_q[i];
         if (accept && (cnt_q == CW'(i))) begin
            acc_d[i] = in_data;
         end
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------

   // Lane counter and accumulator; reset discards any partly packed word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         for (int i = 0; i < RATIO - 1; i++) begin
            acc_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         for (int i = 0; i < RATIO - 1; i++) begin
            acc_q[i] <= acc_d[i];
         end
      end
   end

   // Output register: load on a closing beat (which may coincide with the
   // previous word draining, giving back-to-back words), clear valid once the
   // word is taken, and otherwise hold the word steady.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else if (accept && final_beat) begin
         out_data_q  <= word_d;
         out_valid_q <= 1'b1;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

`ifdef PIPE_WIDTH_PACKER_LAST_EN
   // Sideband for the word in the output register, loaded together with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_last_q  <= 1'b0;
         out_lanes_q <= '0;
      end else if (accept && final_beat) begin
         out_last_q  <= in_last;
         out_lanes_q <= lanes_d;
      end
   end

   assign out_last  = out_last_q;
   assign out_lanes = out_lanes_q;
`endif

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pipe_width_packer.sv
// Self-checking bench for pipe_width_packer (DATAWIDTH=8, RATIO=4). Expected
// words are queued as stimulus is driven and popped by a monitor whenever a
// word transfers; a vector table covers plain streams, hand sequences cover
// backpressure, mid-word reset, pulse timing and the optional last feature.
module tb_pipe_width_packer;

   localparam int DW = 8;
   localparam int R  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW*R-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
`ifdef PIPE_WIDTH_PACKER_LAST_EN
   logic          in_last;
   logic          out_last;
   logic [$clog2(R+1)-1:0] out_lanes;
`endif

   pipe_width_packer #(.DATAWIDTH(DW), .RATIO(R)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
`ifdef PIPE_WIDTH_PACKER_LAST_EN
      .in_last   (in_last),
      .out_last  (out_last),
      .out_lanes (out_lanes),
`endif
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int stall_cnt = 0;
   logic [31:0] exp_q [$];
   logic [31:0] mon_exp;

   typedef struct {
      logic [7:0]  b [4];
      int          gap;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   // Word monitor: every transfer must match the oldest expected word.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %h want none at %0t", out_data, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            check("word", 64'(out_data), 64'(mon_exp));
            $display("word %h expected %h", out_data, mon_exp);
         end
      end
   end

   // Offer one beat and hold it until accepted (bounded wait).
   task automatic send_beat(input logic [7:0] d);
      int n;
      n = 0;
      in_data  = d;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         stall_cnt++;
         n++;
         if (n > 100) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1 for beat %h", d);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
`ifdef PIPE_WIDTH_PACKER_LAST_EN
      in_last  = 1'b0;
`endif
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{b: '{8'h11, 8'h22, 8'h33, 8'h44}, gap: 0, exp: 32'h44332211};
      tbl[1] = '{b: '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, gap: 1, exp: 32'hEFBEADDE};
      tbl[2] = '{b: '{8'h01, 8'h02, 8'h03, 8'h04}, gap: 0, exp: 32'h04030201};
      tbl[3] = '{b: '{8'h05, 8'h06, 8'h07, 8'h08}, gap: 0, exp: 32'h08070605};
      tbl[4] = '{b: '{8'hA5, 8'h5A, 8'hC3, 8'h3C}, gap: 2, exp: 32'h3CC35AA5};

      rst       = 1'b1;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b1;
`ifdef PIPE_WIDTH_PACKER_LAST_EN
      in_last   = 1'b0;
`endif

      // Reset state, sampled between edges while rst is high.
      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Table vectors: streamed, gapped and back-to-back words.
      stall_cnt = 0;
      for (int v = 0; v < 5; v++) begin
         exp_q.push_back(tbl[v].exp);
         for (int k = 0; k < 4; k++) begin
            send_beat(tbl[v].b[k]);
            if (k < 3) idle(tbl[v].gap);
         end
      end
      check("no_stall_streaming", 64'(stall_cnt), 64'd0);
      idle(3);

      // Pulse timing: valid one cycle after the last beat, for one cycle.
      exp_q.push_back(32'h44332211);
      send_beat(8'h11);
      send_beat(8'h22);
      send_beat(8'h33);
      send_beat(8'h44);
      @(negedge clk);
      check("pulse_valid_hi", 64'(out_valid), 64'd1);
      check("pulse_data", 64'(out_data), 64'h44332211);
      @(negedge clk);
      check("pulse_valid_lo", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;

      // Backpressure: word pending, three lanes still accepted, final stalls.
      out_ready = 1'b0;
      exp_q.push_back(32'h44332211);
      exp_q.push_back(32'h88776655);
      send_beat(8'h11);
      send_beat(8'h22);
      send_beat(8'h33);
      send_beat(8'h44);
      stall_cnt = 0;
      send_beat(8'h55);
      send_beat(8'h66);
      send_beat(8'h77);
      check("bp_no_stall_lanes", 64'(stall_cnt), 64'd0);
      in_data  = 8'h88;
      in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_in_ready_lo", 64'(in_ready), 64'd0);
         check("bp_hold_valid", 64'(out_valid), 64'd1);
         check("bp_hold_data", 64'(out_data), 64'h44332211);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_in_ready_hi", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_b2b_valid", 64'(out_valid), 64'd1);
      check("bp_b2b_data", 64'(out_data), 64'h88776655);
      idle(3);

      // Reset mid-word: the partial 0xAA,0xBB word must vanish.
      send_beat(8'hAA);
      send_beat(8'hBB);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_out_data", 64'(out_data), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      exp_q.push_back(32'h04030201);
      send_beat(8'h01);
      send_beat(8'h02);
      send_beat(8'h03);
      send_beat(8'h04);
      idle(3);

`ifdef PIPE_WIDTH_PACKER_LAST_EN
      // Early termination: two lanes, then a full word starting at lane 0.
      exp_q.push_back(32'h00002010);
      send_beat(8'h10);
      in_last = 1'b1;
      send_beat(8'h20);
      @(negedge clk);
      check("last_data", 64'(out_data), 64'h00002010);
      check("last_lanes", 64'(out_lanes), 64'd2);
      check("last_flag", 64'(out_last), 64'd1);
      exp_q.push_back(32'h34333231);
      send_beat(8'h31);
      send_beat(8'h32);
      send_beat(8'h33);
      send_beat(8'h34);
      @(negedge clk);
      check("full_data", 64'(out_data), 64'h34333231);
      check("full_lanes", 64'(out_lanes), 64'd4);
      check("full_flag", 64'(out_last), 64'd0);
      idle(3);
`endif

      idle(5);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
